sym9_frame_loader: RTL and testbench

SYM9_FRAME_LOADER -- requirements
Module: sym9_frame_loader

---
 rtl/sym9_frame_loader.sv | 134 +++++++++++++
 tb/tb_sym9_frame_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sym9_frame_loader.sv
// Serial 9-bit frame collector feeding a 9-input symmetric stage.
// Each completed frame is held on vec for SETTLE_CYCLES, then sym_in is captured and offered as a result.
module sym9_frame_loader #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sdata,
    input  logic        svalid,
    output logic        sready,
    input  logic        frame_start,
    output logic [8:0]  vec,
    input  logic        sym_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_data,
    output logic [8:0]  res_vec,
    output logic [15:0] frame_cnt,
    output logic        sync_err
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_OUT    = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic [8:0]  r_shift;
    logic [3:0]  r_bit_cnt;
    logic [3:0]  r_settle;
    logic [8:0]  r_vec;
    logic        r_res_valid;
    logic        r_res_data;
    logic [8:0]  r_res_vec;
    logic [15:0] r_frame_cnt;
    logic        r_sync_err;

    logic        w_handshake;
    logic        w_can_complete;
    logic        w_sready;
    logic        w_accept;
    logic        w_complete;
    logic        w_capture;

    // The 9th bit may only land when the evaluator is free or is freed this very cycle.
    assign w_handshake    = (r_state == S_OUT) && res_ready;
    assign w_can_complete = (r_state == S_IDLE) || w_handshake;
    assign w_sready       = !((r_bit_cnt == 4'd8) && !w_can_complete);
    assign w_accept       = svalid && w_sready;
    assign w_complete     = w_accept && !frame_start && (r_bit_cnt == 4'd8);
    assign w_capture      = (r_state == S_SETTLE) && (r_settle == 4'd0);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:   if (w_complete) w_state_nx = S_SETTLE;
            S_SETTLE: if (r_settle == 4'd0) w_state_nx = S_OUT;
            S_OUT:    if (res_ready) w_state_nx = w_complete ? S_SETTLE : S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_res_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_res_valid <= (w_state_nx == S_OUT);
        end
    end

    // Collector: LSB-first assembly; frame_start restarts at bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift    <= 9'd0;
            r_bit_cnt  <= 4'd0;
            r_vec      <= 9'd0;
            r_sync_err <= 1'b0;
        end else if (w_accept) begin
            if (frame_start) begin
                r_shift   <= {8'd0, sdata};
                r_bit_cnt <= 4'd1;
                if (r_bit_cnt != 4'd0)
                    r_sync_err <= 1'b1;
            end else if (r_bit_cnt == 4'd8) begin
                r_vec     <= {sdata, r_shift[7:0]};
                r_shift   <= 9'd0;
                r_bit_cnt <= 4'd0;
            end else begin
                r_shift[r_bit_cnt] <= sdata;
                r_bit_cnt          <= r_bit_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_settle <= 4'd0;
        end else if (w_complete) begin
            r_settle <= SETTLE_LD;
        end else if ((r_state == S_SETTLE) && (r_settle != 4'd0)) begin
            r_settle <= r_settle - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_data  <= 1'b0;
            r_res_vec   <= 9'd0;
            r_frame_cnt <= 16'd0;
        end else begin
            if (w_capture) begin
                r_res_data <= sym_in;
                r_res_vec  <= r_vec;
            end
            if (w_handshake)
                r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign sready    = w_sready;
    assign vec       = r_vec;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_vec   = r_res_vec;
    assign frame_cnt = r_frame_cnt;
    assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_sym9_frame_loader.sv
// Directed bench for sym9_frame_loader: frame-level scoreboard plus literal spot checks.
module tb_sym9_frame_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sdata = 1'b0;
    logic        svalid = 1'b0;
    logic        sready;
    logic        frame_start = 1'b0;
    logic [8:0]  vec;
    logic        sym_in;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic        res_data;
    logic [8:0]  res_vec;
    logic [15:0] frame_cnt;
    logic        sync_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0]  q[$];
    logic [15:0] exp_cnt = 16'd0;
    logic [8:0]  exp_vec = 9'd0;
    logic        exp_serr = 1'b0;
    logic        mid = 1'b0;
    logic        pend = 1'b0;

    sym9_frame_loader #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .sdata(sdata), .svalid(svalid), .sready(sready),
        .frame_start(frame_start), .vec(vec), .sym_in(sym_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_vec(res_vec), .frame_cnt(frame_cnt), .sync_err(sync_err)
    );

    function automatic logic symf(logic [8:0] v);
        int c;
        c = $countones(v);
        return (c >= 3) && (c <= 6);
    endfunction

    assign sym_in = symf(vec);

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Scoreboard: results must come out in completion order with the rule-derived value.
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                exp_cnt = exp_cnt + 16'd1;
                if (q.size() > 0) void'(q.pop_front());
                pend = 1'b0;
            end
            chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
            chk("vec", 32'(vec), 32'(exp_vec));
            chk("sync_err", 32'(sync_err), 32'(exp_serr));
            if (res_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_res_valid", 32'(res_valid), 32'd0);
                end else begin
                    chk("res_vec", 32'(res_vec), 32'(q[0]));
                    chk("res_data", 32'(res_data), 32'(symf(q[0])));
                    if (res_ready) pend = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(logic b, logic fs);
        int n;
        sdata = b; frame_start = fs; svalid = 1'b1;
        #1;
        n = 0;
        while (!sready && n < 200) begin
            tick();
            n++;
        end
        if (n == 200) chk("sready_timeout", 32'(sready), 32'd1);
        tick();
        svalid = 1'b0; frame_start = 1'b0;
    endtask

    task automatic send_frame(logic [8:0] f);
        for (int i = 0; i < 9; i++) begin
            send_bit(f[i], i == 0);
            if (i == 0 && mid) exp_serr = 1'b1;
        end
        mid = 1'b0;
        q.push_back(f);
        exp_vec = f;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!res_valid && n < 30) begin
            tick();
            n++;
        end
        if (n == 30) chk("res_valid_timeout", 32'(res_valid), 32'd1);
    endtask

    task automatic run_frame(logic [8:0] f, logic expd, string nm);
        send_frame(f);
        wait_valid();
        chk(nm, 32'(res_data), 32'(expd));
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        exp_cnt = 16'd0; exp_vec = 9'd0; exp_serr = 1'b0; mid = 1'b0;
        sdata = 1'b0; svalid = 1'b0; frame_start = 1'b0;
        #1;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_vec", 32'(vec), 32'd0);
        chk("rst_res_vec", 32'(res_vec), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_sync_err", 32'(sync_err), 32'd0);
        chk("rst_sready", 32'(sready), 32'd1);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        tick();

        // Basic frame and exact result latency
        res_ready = 1'b1;
        send_frame(9'h007);
        chk("lat_e0", 32'(res_valid), 32'd0);
        tick();
        chk("lat_e1", 32'(res_valid), 32'd0);
        tick();
        chk("lat_e2", 32'(res_valid), 32'd1);
        chk("basic_data", 32'(res_data), 32'd1);
        chk("basic_vec", 32'(res_vec), 32'h007);
        tick();
        chk("lat_e3", 32'(res_valid), 32'd0);
        chk("basic_cnt", 32'(frame_cnt), 32'd1);

        // Popcount boundaries
        run_frame(9'h003, 1'b0, "pop2");
        run_frame(9'h1FF, 1'b0, "pop9");
        run_frame(9'h07F, 1'b0, "pop7");
        run_frame(9'h03F, 1'b1, "pop6");
        run_frame(9'h0AA, 1'b1, "pop4");
        run_frame(9'h038, 1'b1, "pop3");

        // Truncated frame: 5 bits then a restart
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        mid = 1'b1;
        chk("trunc_before", 32'(sync_err), 32'd0);
        run_frame(9'h155, 1'b1, "trunc_data");
        chk("trunc_serr", 32'(sync_err), 32'd1);
        run_frame(9'h001, 1'b0, "trunc_next");
        chk("trunc_sticky", 32'(sync_err), 32'd1);

        // Reset during SETTLE discards the pending frame
        send_frame(9'h0F0);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_valid", 32'(res_valid), 32'd0);
            tick();
        end
        run_frame(9'h10F, 1'b1, "post_rst");
        chk("post_rst_cnt", 32'(frame_cnt), 32'd1);

        // Back-pressure: second frame stalls on its 9th bit
        do_reset();
        res_ready = 1'b0;
        send_frame(9'h0C3);
        for (int i = 0; i < 8; i++) send_bit(1'b1, i == 0);
        chk("bp_sready_low", 32'(sready), 32'd0);
        sdata = 1'b0; svalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 19) begin
                chk("bp_stall", 32'(sready), 32'd0);
                chk("bp_res_vec", 32'(res_vec), 32'h0C3);
                chk("bp_vec", 32'(vec), 32'h0C3);
                chk("bp_valid", 32'(res_valid), 32'd1);
                chk("bp_cnt0", 32'(frame_cnt), 32'd0);
            end
        end
        res_ready = 1'b1;
        #1;
        chk("bp_sready_hs", 32'(sready), 32'd1);
        tick();
        svalid = 1'b0;
        q.push_back(9'h0FF);
        exp_vec = 9'h0FF;
        chk("bp_settle", 32'(res_valid), 32'd0);
        chk("bp_cnt1", 32'(frame_cnt), 32'd1);
        chk("bp_vec2", 32'(vec), 32'h0FF);
        wait_valid();
        chk("bp_data2", 32'(res_data), 32'd0);
        tick();
        chk("bp_cnt2", 32'(frame_cnt), 32'd2);

        // Counter wrap
        tick();
        force dut.r_frame_cnt = 16'hFFFE;
        exp_cnt = 16'hFFFE;
        tick();
        release dut.r_frame_cnt;
        tick();
        run_frame(9'h00F, 1'b1, "wrap_a");
        chk("wrap_ffff", 32'(frame_cnt), 32'h0000FFFF);
        run_frame(9'h011, 1'b0, "wrap_b");
        chk("wrap_zero", 32'(frame_cnt), 32'd0);

        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
